// File: rtl/thread_fetch_if.sv
// Fetch-stage bundle: instruction memory port, decoded-op handshake,
// branch condition flags, Ret redirect and halt status.
interface thread_fetch_if;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic        out_pid;
    logic [7:0]  out_op;
    logic [15:0] out_immed;
    logic [1:0]  torf_valid;
    logic [1:0]  torf;
    logic        redir_valid;
    logic        redir_pid;
    logic [15:0] redir_pc;
    logic [1:0]  halted;
    logic        halt;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output out_valid,
        input  out_ready,
        output out_pid,
        output out_op,
        output out_immed,
        input  torf_valid,
        input  torf,
        input  redir_valid,
        input  redir_pid,
        input  redir_pc,
        output halted,
        output halt
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  out_valid,
        output out_ready,
        input  out_pid,
        input  out_op,
        input  out_immed,
        output torf_valid,
        output torf,
        output redir_valid,
        output redir_pid,
        output redir_pc,
        input  halted,
        input  halt
    );
endinterface

// File: rtl/thread_fetch.sv
// Two-thread interleaved fetch: per-thread PCs, Pre folding, local branch
// resolution, Ret parking and Sys retirement, one registered op per cycle.
module thread_fetch #(
    parameter logic [15:0] PC0_RESET = 16'h0000,
    parameter logic [15:0] PC1_RESET = 16'h8000
) (
    input  logic           clk,
    input  logic           reset,
    thread_fetch_if.master bus
);
    typedef enum logic [1:0] {RUN, WAIT_RET, HALTED} mode_e;

    logic [1:0][15:0] pc_q, pc_d;
    logic [1:0][3:0]  pre_q, pre_d;
    logic [1:0]       preset_q, preset_d;
    mode_e            mode_q [2];
    mode_e            mode_d [2];
    logic             pid_q, pid_d;
    logic             out_valid_q, out_valid_d;
    logic             out_pid_q, out_pid_d;
    logic [7:0]       out_op_q, out_op_d;
    logic [15:0]      out_immed_q, out_immed_d;

    logic        hold;
    logic [15:0] ir, pc_cur, pc_inc, tgt, next_pc, immed;
    logic [3:0]  opc;
    logic        emit, consume;

    function automatic logic [15:0] sext12(input logic signed [11:0] v);
        logic signed [15:0] w;
        w = v;
        return w;
    endfunction

    assign hold          = out_valid_q && !bus.out_ready;
    assign bus.imem_addr = pc_q[pid_q];
    assign bus.out_valid = out_valid_q;
    assign bus.out_pid   = out_pid_q;
    assign bus.out_op    = out_op_q;
    assign bus.out_immed = out_immed_q;
    assign bus.halted    = {mode_q[1] == HALTED, mode_q[0] == HALTED};
    assign bus.halt      = &bus.halted;

    always_comb begin
        pc_d        = pc_q;
        pre_d       = pre_q;
        preset_d    = preset_q;
        mode_d      = mode_q;
        pid_d       = pid_q;
        out_valid_d = out_valid_q;
        out_pid_d   = out_pid_q;
        out_op_d    = out_op_q;
        out_immed_d = out_immed_q;
        ir          = bus.imem_rdata;
        opc         = ir[15:12];
        pc_cur      = pc_q[pid_q];
        pc_inc      = pc_cur + 16'd1;
        tgt         = preset_q[pid_q] ? {pre_q[pid_q], ir[11:0]} : {pc_cur[15:12], ir[11:0]};
        next_pc     = pc_inc;
        immed       = {4'h0, ir[11:0]};
        emit        = 1'b0;
        consume     = 1'b0;

        if (!hold) begin
            pid_d = ~pid_q;
            if (mode_q[pid_q] == RUN) begin
                consume = 1'b1;
                case (opc)
                    4'h0: begin
                        emit = 1'b1;
                        if (ir[3:0] == 4'ha) begin
                            next_pc        = pc_cur;
                            mode_d[pid_q]  = WAIT_RET;
                        end else if (ir[3:0] == 4'hb) begin
                            emit           = 1'b0;
                            next_pc        = pc_cur;
                            mode_d[pid_q]  = HALTED;
                        end
                    end
                    4'h1: begin
                        emit  = 1'b1;
                        immed = preset_q[pid_q] ? {pre_q[pid_q], ir[11:0]} : sext12(ir[11:0]);
                    end
                    4'h4: begin
                        emit    = 1'b1;
                        immed   = pc_inc;
                        next_pc = tgt;
                    end
                    4'h5: next_pc = tgt;
                    4'h6, 4'h7: begin
                        // A branch without a current flag is not consumed: retried next slot.
                        if (!bus.torf_valid[pid_q]) begin
                            consume = 1'b0;
                            next_pc = pc_cur;
                        end else begin
                            next_pc = (bus.torf[pid_q] ^ (opc == 4'h6)) ? tgt : pc_inc;
                        end
                    end
                    4'h8, 4'h9, 4'ha: emit = 1'b1;
                    4'hb: begin
                        pre_d[pid_q]    = ir[3:0];
                        preset_d[pid_q] = 1'b1;
                    end
                    default: ;
                endcase
                pc_d[pid_q] = next_pc;
                if (consume && opc != 4'hb)
                    preset_d[pid_q] = 1'b0;
            end
            out_valid_d = emit;
            if (emit) begin
                out_pid_d   = pid_q;
                out_op_d    = {opc, (opc == 4'h0) ? ir[3:0] : 4'h0};
                out_immed_d = immed;
            end
        end

        // Redirect capture is independent of the hold and of the slot owner.
        for (int i = 0; i < 2; i++) begin
            if (bus.redir_valid && bus.redir_pid == 1'(i) && mode_q[i] == WAIT_RET) begin
                pc_d[i]   = bus.redir_pc;
                mode_d[i] = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= {PC1_RESET, PC0_RESET};
            pre_q       <= '0;
            preset_q    <= '0;
            mode_q[0]   <= RUN;
            mode_q[1]   <= RUN;
            pid_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_pid_q   <= 1'b0;
            out_op_q    <= 8'h00;
            out_immed_q <= 16'h0000;
        end else begin
            pc_q        <= pc_d;
            pre_q       <= pre_d;
            preset_q    <= preset_d;
            mode_q[0]   <= mode_d[0];
            mode_q[1]   <= mode_d[1];
            pid_q       <= pid_d;
            out_valid_q <= out_valid_d;
            out_pid_q   <= out_pid_d;
            out_op_q    <= out_op_d;
            out_immed_q <= out_immed_d;
        end
    end
endmodule
